// File: rtl/ddr3_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_ctrl_pkg
// Shared types and default timing constants for the DDR3 refresh arbiter.
//   ref_arb_state_t   : arbiter FSM state encoding
//   DDR3_TREFI_CK     : default refresh interval in clocks (7.8 us @ 2.5 ns)
//   DDR3_TRFC_CK      : default refresh cycle time in clocks (160 ns @ 2.5 ns)
//   DDR3_MAX_POSTPONE : default limit of owed refreshes
//   sat_inc16()       : saturating 16-bit increment for statistics counters
// ----------------------------------------------------------------------------
package ddr3_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU      = 2'd1,
    REF_REQ  = 2'd2,
    REF_WAIT = 2'd3
  } ref_arb_state_t;

  localparam int DDR3_TREFI_CK     = 3120;
  localparam int DDR3_TRFC_CK      = 64;
  localparam int DDR3_MAX_POSTPONE = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ddr3_refi_timer.sv
// ----------------------------------------------------------------------------
// ddr3_refi_timer
// tREFI interval counter plus the owed-refresh bookkeeping.
//   clk        in  : i_cpu_ck domain clock
//   rst        in  : synchronous active-high reset
//   init_done  in  : timer and pending count held at 0 while low
//   ref_ack    in  : one-cycle pulse, a REFRESH was issued (pending - 1)
//   tick       out : high in the wrap cycle of the interval counter
//   pending    out : owed refresh count, 0..MAX_POSTPONE
//   overflow   out : sticky, a tick arrived with pending already at the limit
// ----------------------------------------------------------------------------
module ddr3_refi_timer
  import ddr3_ctrl_pkg::*;
#(
  parameter int TREFI_CK     = DDR3_TREFI_CK,
  parameter int MAX_POSTPONE = DDR3_MAX_POSTPONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       ref_ack,
  output logic       tick,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int TW = (TREFI_CK > 1) ? $clog2(TREFI_CK) : 1;
  localparam logic [TW-1:0] INTERVAL_LAST = TW'(TREFI_CK - 1);
  localparam logic [3:0]    PEND_MAX      = 4'(MAX_POSTPONE);

  logic [TW-1:0] interval;

  assign tick = init_done && (interval == INTERVAL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      interval <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (!init_done) begin
      interval <= '0;
      pending  <= '0;
    end else begin
      interval <= tick ? '0 : interval + 1'b1;
      // A tick and an ack in the same cycle cancel out.
      if (tick && !ref_ack) begin
        if (pending == PEND_MAX)
          overflow <= 1'b1;
        else
          pending <= pending + 4'd1;
      end else if (ref_ack && !tick && (pending != 4'd0)) begin
        pending <= pending - 4'd1;
      end
    end
  end

endmodule

// File: rtl/ddr3_refresh_arbiter.sv
// ----------------------------------------------------------------------------
// ddr3_refresh_arbiter
// Grants the DDR3 command path either to the CPU or to a PRECHARGE-ALL +
// REFRESH sequence, then blocks traffic for tRFC. Refreshes may be postponed
// up to MAX_POSTPONE while the CPU is busy.
//   i_cpu_ck        in      : clock, rising edge
//   i_cpu_rst       in      : synchronous active-high reset
//   i_init_done     in      : arbiter dormant in IDLE while low
//   i_cpu_req       in      : CPU transaction pending (level)
//   i_cpu_done      in      : pulse, CPU transaction finished, banks precharged
//   i_ref_ack       in      : pulse, command generator issued REFRESH
//   o_cpu_gnt       out     : command path owned by the CPU
//   o_ref_req       out     : precharge all banks and issue REFRESH
//   o_ref_busy      out     : inside the tRFC window
//   o_ref_pending   out [4] : owed refresh count
//   o_ref_overflow  out     : sticky postpone-limit overflow
// Optional (macro DDR3_REF_STATS_EN):
//   o_ref_issued    out [16]: saturating count of i_ref_ack pulses
//   o_ref_forced    out [16]: saturating count of refreshes forced over a CPU request
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nobody owns the command path; pick the next owner
// CPU      | CPU transaction in flight, never pre-empted
// REF_REQ  | asking the command generator for PRECHARGE-ALL + REFRESH
// REF_WAIT | REFRESH issued, traffic blocked for TRFC_CK cycles
// ----------------------------------------------------------------------------
module ddr3_refresh_arbiter
  import ddr3_ctrl_pkg::*;
#(
  parameter int TREFI_CK     = DDR3_TREFI_CK,
  parameter int TRFC_CK      = DDR3_TRFC_CK,
  parameter int MAX_POSTPONE = DDR3_MAX_POSTPONE
) (
  input  logic        i_cpu_ck,
  input  logic        i_cpu_rst,
  input  logic        i_init_done,
  input  logic        i_cpu_req,
  input  logic        i_cpu_done,
  input  logic        i_ref_ack,
  output logic        o_cpu_gnt,
  output logic        o_ref_req,
  output logic        o_ref_busy,
  output logic [3:0]  o_ref_pending,
  output logic        o_ref_overflow
`ifdef DDR3_REF_STATS_EN
  ,
  output logic [15:0] o_ref_issued,
  output logic [15:0] o_ref_forced
`endif
);

  localparam int RW = $clog2(TRFC_CK + 1);
  localparam logic [RW-1:0] RFC_LOAD = RW'(TRFC_CK - 1);
  localparam logic [3:0]    PEND_MAX = 4'(MAX_POSTPONE);

  ref_arb_state_t state;
  logic [RW-1:0]  rfc_cnt;

  ddr3_refi_timer #(
    .TREFI_CK     (TREFI_CK),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_refi_timer (
    .clk       (i_cpu_ck),
    .rst       (i_cpu_rst),
    .init_done (i_init_done),
    .ref_ack   (i_ref_ack),
    .tick      (),
    .pending   (o_ref_pending),
    .overflow  (o_ref_overflow)
  );

  // Outputs are registered together with the state so each one is a pure
  // function of the state register.
  always_ff @(posedge i_cpu_ck) begin
    if (i_cpu_rst) begin
      state      <= IDLE;
      rfc_cnt    <= '0;
      o_cpu_gnt  <= 1'b0;
      o_ref_req  <= 1'b0;
      o_ref_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_init_done) begin
            if (o_ref_pending == PEND_MAX) begin
              state     <= REF_REQ;
              o_ref_req <= 1'b1;
            end else if (i_cpu_req) begin
              state     <= CPU;
              o_cpu_gnt <= 1'b1;
            end else if (o_ref_pending != 4'd0) begin
              state     <= REF_REQ;
              o_ref_req <= 1'b1;
            end
          end
        end
        CPU: begin
          if (i_cpu_done) begin
            state     <= IDLE;
            o_cpu_gnt <= 1'b0;
          end
        end
        REF_REQ: begin
          if (i_ref_ack) begin
            state      <= REF_WAIT;
            o_ref_req  <= 1'b0;
            o_ref_busy <= 1'b1;
            rfc_cnt    <= RFC_LOAD;
          end
        end
        REF_WAIT: begin
          // Loaded with TRFC_CK-1; the exit edge is the TRFC_CK-th busy cycle.
          if (rfc_cnt == '0) begin
            state      <= IDLE;
            o_ref_busy <= 1'b0;
          end else begin
            rfc_cnt <= rfc_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          o_cpu_gnt  <= 1'b0;
          o_ref_req  <= 1'b0;
          o_ref_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DDR3_REF_STATS_EN
  logic forced_take;

  assign forced_take = (state == IDLE) && i_init_done &&
                       (o_ref_pending == PEND_MAX) && i_cpu_req;

  always_ff @(posedge i_cpu_ck) begin
    if (i_cpu_rst) begin
      o_ref_issued <= '0;
      o_ref_forced <= '0;
    end else begin
      if (i_ref_ack)
        o_ref_issued <= sat_inc16(o_ref_issued);
      if (forced_take)
        o_ref_forced <= sat_inc16(o_ref_forced);
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_refresh_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr3_refresh_arbiter
// Self-checking bench for ddr3_refresh_arbiter with TREFI_CK=16, TRFC_CK=4.
// A behavioural model tracks ownership, the interval and the owed count and
// is compared with the DUT after every clock; directed sequences add fixed
// expectations for the corner cases.
// ----------------------------------------------------------------------------
module tb_ddr3_refresh_arbiter;

  localparam int TREFI = 16;
  localparam int TRFC  = 4;
  localparam int MAXP  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, init, cpu_req, cpu_done, ref_ack;
  logic       gnt, rreq, busy, ovf;
  logic [3:0] pend;
`ifdef DDR3_REF_STATS_EN
  logic [15:0] issued, forced;
`endif

  ddr3_refresh_arbiter #(
    .TREFI_CK     (TREFI),
    .TRFC_CK      (TRFC),
    .MAX_POSTPONE (MAXP)
  ) dut (
    .i_cpu_ck       (clk),
    .i_cpu_rst      (rst),
    .i_init_done    (init),
    .i_cpu_req      (cpu_req),
    .i_cpu_done     (cpu_done),
    .i_ref_ack      (ref_ack),
    .o_cpu_gnt      (gnt),
    .o_ref_req      (rreq),
    .o_ref_busy     (busy),
    .o_ref_pending  (pend),
    .o_ref_overflow (ovf)
`ifdef DDR3_REF_STATS_EN
    ,
    .o_ref_issued   (issued),
    .o_ref_forced   (forced)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the path, how long tRFC still blocks, owed count.
  int m_timer, m_pend, m_busy_left, m_issued, m_forced;
  bit m_gnt, m_req, m_ovf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got timeout expected event at %0t", name, $time);
  endtask

  function automatic logic [7:0] dut_vec();
    return {gnt, rreq, busy, pend, ovf};
  endfunction

  function automatic logic [7:0] model_vec();
    return {m_gnt, m_req, (m_busy_left > 0), 4'(m_pend), m_ovf};
  endfunction

  task automatic model_step();
    int tick, np;
    if (rst) begin
      m_timer = 0; m_pend = 0; m_busy_left = 0; m_issued = 0; m_forced = 0;
      m_gnt = 0; m_req = 0; m_ovf = 0;
      return;
    end
    tick = (init && m_timer == TREFI - 1) ? 1 : 0;
    if (m_gnt) begin
      if (cpu_done) m_gnt = 0;
    end else if (m_req) begin
      if (ref_ack) begin
        m_req = 0;
        m_busy_left = TRFC;
      end
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (init) begin
      if (m_pend == MAXP) begin
        m_req = 1;
        if (cpu_req && m_forced < 65535) m_forced++;
      end else if (cpu_req) begin
        m_gnt = 1;
      end else if (m_pend > 0) begin
        m_req = 1;
      end
    end
    if (ref_ack && m_issued < 65535) m_issued++;
    if (!init) begin
      m_timer = 0;
      m_pend  = 0;
    end else begin
      m_timer = (m_timer + 1) % TREFI;
      np = m_pend + tick - int'(ref_ack);
      if (np > MAXP) begin
        np = MAXP;
        m_ovf = 1;
      end
      if (np < 0) np = 0;
      m_pend = np;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_outputs", 32'(dut_vec()), 32'(model_vec()));
`ifdef DDR3_REF_STATS_EN
    check("model_issued", 32'(issued), 32'(m_issued));
    check("model_forced", 32'(forced), 32'(m_forced));
`endif
  endtask

  task automatic idle_inputs();
    init = 0; cpu_req = 0; cpu_done = 0; ref_ack = 0;
  endtask

  task automatic do_reset();
    rst      = 1;
    init     = 1'($urandom_range(0, 1));
    cpu_req  = 1'($urandom_range(0, 1));
    cpu_done = 1'($urandom_range(0, 1));
    ref_ack  = 1'($urandom_range(0, 1));
    cycle();
    cycle();
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    rst = 0;
    idle_inputs();
  endtask

  typedef struct {
    bit rst, init, req, done, ack;
    bit e_gnt, e_rreq, e_busy;
    int e_pend;
    bit e_ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit hit;
    int k;

    rst = 1;
    idle_inputs();
    m_timer = 0; m_pend = 0; m_busy_left = 0; m_issued = 0; m_forced = 0;
    m_gnt = 0; m_req = 0; m_ovf = 0;

    // rst init req done ack | gnt rreq busy pend ovf
    tbl[0] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; init = tbl[i].init; cpu_req = tbl[i].req;
      cpu_done = tbl[i].done; ref_ack = tbl[i].ack;
      cycle();
      check($sformatf("tbl_row%0d", i), 32'(dut_vec()),
            32'({tbl[i].e_gnt, tbl[i].e_rreq, tbl[i].e_busy, 4'(tbl[i].e_pend), tbl[i].e_ovf}));
    end

    // Idle refresh: timer frozen while dormant, then first tick after 16 clocks.
    do_reset();
    repeat (20) cycle();
    check("dormant_pending", 32'(pend), 32'd0);
    init = 1;
    k = 0; hit = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      k++;
      if (pend != 4'd0) begin hit = 1; break; end
    end
    if (!hit) timeout("idle_tick");
    check("idle_tick_cycle", 32'(k), 32'd16);
    check("idle_pending_one", 32'(pend), 32'd1);
    cycle();
    check("idle_ref_req", 32'(rreq), 32'd1);
    cycle();
    check("idle_ref_req_hold", 32'(rreq), 32'd1);
    ref_ack = 1;
    cycle();
    ref_ack = 0;
    check("ack_outputs", 32'({rreq, busy, pend}), 32'({1'b0, 1'b1, 4'd0}));
    k = 1; hit = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (busy) k++;
      else begin hit = 1; break; end
    end
    if (!hit) timeout("busy_window");
    check("busy_len", 32'(k), 32'(TRFC));

    // Postpone: CPU keeps the path, refresh forced once 8 are owed.
    do_reset();
    init = 1; cpu_req = 1;
    hit = 0;
    for (int i = 1; i <= 400; i++) begin
      cpu_done = (i % 20 == 0);
      cycle();
      if (rreq) begin hit = 1; break; end
    end
    cpu_done = 0;
    if (!hit) timeout("postpone_force");
    check("postpone_pending", 32'(pend), 32'd8);
    check("postpone_gnt", 32'(gnt), 32'd0);
`ifdef DDR3_REF_STATS_EN
    check("postpone_forced", 32'(forced), 32'd1);
`endif
    ref_ack = 1;
    cycle();
    ref_ack = 0;
    check("postpone_after_ack", 32'({busy, pend}), 32'({1'b1, 4'd7}));

    // Overflow: CPU holds the path for nine intervals.
    do_reset();
    init = 1; cpu_req = 1;
    repeat (9 * TREFI + 2) cycle();
    check("ovf_pending", 32'(pend), 32'd8);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_gnt_held", 32'(gnt), 32'd1);
    cpu_req = 0; cpu_done = 1;
    cycle();
    cpu_done = 0;
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      ref_ack = rreq;
      cycle();
      ref_ack = 0;
      if (pend == 4'd0 && !rreq && !busy) begin hit = 1; break; end
    end
    ref_ack = 0;
    if (!hit) timeout("ovf_drain");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Simultaneous tick and ack at pending 3.
    do_reset();
    init = 1; cpu_req = 1;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (pend == 4'd3) begin hit = 1; break; end
    end
    if (!hit) timeout("sim_reach3");
    cpu_req = 0; cpu_done = 1;
    cycle();
    cpu_done = 0;
    cycle();
    check("sim_ref_req", 32'({rreq, pend}), 32'({1'b1, 4'd3}));
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_timer == TREFI - 1) begin hit = 1; break; end
      cycle();
    end
    if (!hit) timeout("sim_align");
    ref_ack = 1;
    cycle();
    ref_ack = 0;
    check("sim_pending_kept", 32'(pend), 32'd3);
    check("sim_busy", 32'(busy), 32'd1);

    // Reset inside the tRFC window.
    rst = 1;
    cycle();
    check("midop_reset", 32'(dut_vec()), 32'd0);
    rst = 0;
    cycle();

    // Randomized traffic against the model.
    init = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) init = ~init;
      if ($urandom_range(0, 7) == 0) cpu_req = 1'($urandom_range(0, 1));
      cpu_done = gnt  ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
      ref_ack  = rreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr3_refresh_arbiter.md
# ddr3_refresh_arbiter

Sequences access to the DDR3 command path between CPU transactions and periodic auto-refresh. Lives inside `DDR3_Controller` on the `i_cpu_ck` domain, between the CPU request decode and the command generator. Tracks the tREFI interval and counts owed refreshes, postponing up to 8. It grants the command path either to the CPU or to a PRECHARGE-ALL + REFRESH sequence, then blocks traffic for tRFC.

## Interface
Parameters:
- `TREFI_CK`, 3120: refresh interval in `i_cpu_ck` cycles (7.8 us at 2.5 ns).
- `TRFC_CK`, 64: refresh cycle time in clocks (160 ns at 2.5 ns).
- `MAX_POSTPONE`, 8: maximum owed refreshes (JEDEC limit).

Ports:
- `i_cpu_ck` in 1: the single clock; all logic is on its rising edge.
- `i_cpu_rst` in 1: synchronous, active-high reset.
- `i_init_done` in 1: controller init/ZQ complete; the arbiter is dormant while low.
- `i_cpu_req` in 1: CPU transaction pending (level).
- `i_cpu_done` in 1: one-cycle pulse; the CPU transaction has finished and all banks are precharged.
- `i_ref_ack` in 1: one-cycle pulse; the command generator issued REFRESH.
- `o_cpu_gnt` out 1: command path owned by the CPU.
- `o_ref_req` out 1: command generator must precharge all banks and issue REFRESH.
- `o_ref_busy` out 1: inside the tRFC window.
- `o_ref_pending` out 4: owed refresh count, 0..`MAX_POSTPONE`.
- `o_ref_overflow` out 1: sticky; set when a tREFI tick arrives with the count already at `MAX_POSTPONE`.

## Operation
- Interval timer counts 0..`TREFI_CK`-1 while `i_init_done`=1 and wraps to 0. The wrap cycle is the "tick". While `i_init_done`=0 the timer and the pending count are held at 0.
- Pending count updates:
  - +1 on tick; -1 on `i_ref_ack`.
  - Tick and ack in the same cycle: no change.
  - Tick at `MAX_POSTPONE`: the count stays at `MAX_POSTPONE` and `o_ref_overflow` is set. It clears only on reset.
- FSM states: IDLE, CPU, REF_REQ, REF_WAIT.
- IDLE: evaluated only when `i_init_done`=1. Priority order:
  1. pending == `MAX_POSTPONE` -> REF_REQ, even if `i_cpu_req`=1.
  2. `i_cpu_req`=1 -> CPU.
  3. pending > 0 -> REF_REQ (opportunistic refresh).
  4. Otherwise stay in IDLE.
- CPU: `o_cpu_gnt`=1. Stays here until `i_cpu_done`, then goes to IDLE. CPU transactions are never pre-empted.
- REF_REQ: `o_ref_req`=1 until `i_ref_ack`, then REF_WAIT. `i_cpu_done` is ignored here.
- REF_WAIT: `o_ref_busy`=1 for exactly `TRFC_CK` cycles, then IDLE. Back-to-back refreshes are permitted through the normal IDLE priority.
- Outputs are decoded from registered state (Moore).

## Timing
- Reset values: `o_cpu_gnt`=0, `o_ref_req`=0, `o_ref_busy`=0, `o_ref_pending`=0, `o_ref_overflow`=0. State IDLE, timer 0.
- Grant latency: `i_cpu_req` sampled high in IDLE gives `o_cpu_gnt`=1 at the next edge (1 cycle).
- `o_cpu_gnt` falls on the edge after `i_cpu_done`. The earliest next grant comes one cycle later, because IDLE costs one cycle.
- `o_ref_req` rises 1 cycle after the IDLE decision and falls on the edge after `i_ref_ack`.
- `o_ref_busy` is high from the edge after `i_ref_ack` for `TRFC_CK` cycles.
- `o_ref_pending` updates on the edge after a tick or ack.
- Reset mid-transaction: every output drops at the next edge regardless of state. Owed refreshes are discarded.
- `i_init_done` falling mid-operation: the FSM completes its current state, then holds in IDLE.

## Configuration
- `DDR3_REF_STATS_EN`: when defined, adds `o_ref_issued` (out 16) and `o_ref_forced` (out 16). Both are saturating counters, reset to 0.
  - `o_ref_issued` increments on each `i_ref_ack`.
  - `o_ref_forced` increments on each IDLE -> REF_REQ taken at `MAX_POSTPONE` while `i_cpu_req`=1.
- When the macro is undefined, these ports and counters do not exist.

## Structure
- `ddr3_ctrl_pkg` holds:
  - `ref_arb_state_t` (IDLE, CPU, REF_REQ, REF_WAIT);
  - default constants `DDR3_TREFI_CK`=3120, `DDR3_TRFC_CK`=64, `DDR3_MAX_POSTPONE`=8.
- One sub-module, `ddr3_refi_timer`: interval counter, pending counter, overflow flag. It exposes tick, pending and overflow. The FSM and the tRFC counter stay in the top module.

## Test plan
Benches use `TREFI_CK`=16, `TRFC_CK`=4.
1. Reset: assert `i_cpu_rst` for 2 cycles with random inputs -> all outputs 0. The timer does not advance while `i_init_done`=0.
2. Idle refresh: `i_init_done`=1 with no CPU traffic -> pending goes to 1 at cycle 16, then `o_ref_req`. Ack -> `o_ref_busy` for 4 cycles -> pending 0.
3. Postpone: `i_cpu_req` held high, `i_cpu_done` pulsed every 20 cycles, no idle gaps -> pending climbs to 8. The next IDLE goes to REF_REQ despite `i_cpu_req`; `o_ref_forced`=1 with `DDR3_REF_STATS_EN` defined.
4. Overflow: hold the FSM in CPU (no `i_cpu_done`) for 9×16 cycles -> pending saturates at 8 and `o_ref_overflow`=1. It stays set after 8 refreshes drain.
5. Simultaneous: align `i_ref_ack` with a tick at pending=3 -> pending stays 3.
6. Reset mid-op: assert `i_cpu_rst` during REF_WAIT with `o_cpu_gnt` history -> next edge gives IDLE, all outputs 0, pending 0.
